imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Pipelined instruction encoder, the inverse of the immediate decoder.
- Takes opcode, funct fields, register indices and a full 32-bit immediate, and packs them into a 32-bit RV32I instruction word.
- Flags any immediate that the selected format cannot represent exactly.
- Sits between a test/program generator (or self-modifying-code path) and instruction memory write port; valid/ready on both sides.

Parameters:
- CNT_W, 8, width of saturating error counter oErrCount.

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  asynchronous, active-high reset
- iValid  in  1  upstream request valid
- oReady  out  1  encoder can accept request this cycle
- iOpcode  in  7  instruction opcode [6:0]
- iFunct3  in  3  funct3
- iFunct7  in  7  funct7 (R-type; CSR-imm upper field)
- iRd  in  5  destination register
- iRs1  in  5  source register 1
- iRs2  in  5  source register 2
- iImm  in  32  immediate in decoded (sign-extended, byte-offset) form
- oValid  out  1  encoded word valid
- iReady  in  1  downstream accepts word
- oInstr  out  32  encoded instruction
- oErr  out  1  immediate not representable / unknown opcode; qualified by oValid
- oErrCount  out  CNT_W  number of errored words handed off

Behaviour:
- Reset: asynchronous on iRST high; all stage valids=0, oValid=0, oInstr=0, oErr=0, oErrCount=0; any in-flight request is discarded.
- Stage S1 registers inputs.
- Stage S2 holds encoded oInstr/oErr.
- Latency: 2 cycles from accept (iValid&oReady) to oValid.
- Throughput: 1 per cycle with iReady=1.
- S2 loads when S2 empty or (oValid&iReady).
- S1 loads when S1 empty or S1 advancing.
- oReady = ~S1valid | (S1 advancing); combinational from iReady.
- Stalled stages hold all data; oInstr/oErr stable while oValid&~iReady.
- Formats (bit layout per RV32I):
  - I-type (0000011, 0010011, 1100111): [31:20]=iImm[11:0]. Error unless iImm[31:11] all equal.
  - S (0100011): [31:25]=iImm[11:5], [11:7]=iImm[4:0]. Same range rule as I.
  - B (1100011): [31]=iImm[12], [30:25]=iImm[10:5], [11:8]=iImm[4:1], [7]=iImm[11]. Error if iImm[0]=1 or iImm[31:12] not all equal.
  - U (0110111, 0010111): [31:12]=iImm[31:12]. Error if iImm[11:0]!=0.
  - J (1101111): [31]=iImm[20], [30:21]=iImm[10:1], [20]=iImm[11], [19:12]=iImm[19:12]. Error if iImm[0]=1 or iImm[31:20] not all equal.
  - R (0110011): [31:25]=iFunct7, no imm check.
  - SYSTEM (1110011): I-type layout; [31:20]=iImm[11:0], CSR address. No range check.
- Register fields: rd [11:7], rs1 [19:15], rs2 [24:20] and funct3 [14:12] are inserted only where the format has them; unused fields=0.
- Opcode [6:0]=iOpcode.
- Unknown opcode: oInstr=32'h00000013 (NOP), oErr=1.
- On error the truncated encoding is still emitted (except unknown opcode).
- oErrCount increments on each handoff (oValid&iReady) with oErr=1; saturates at all-ones and never wraps.

Optional Feature:
- Macro IMMENC_CSR_EN.
- Defined: SYSTEM with funct3 101/110/111 uses CSR-immediate form.
  - [31:20]={iFunct7,iRs2}, rd and funct3 as usual.
  - 101/110: rs1 field=iImm[4:0]; error if iImm[31:5]!=0.
  - 111: rs1 field=~iImm[4:0] (immediate arrives in complemented decoded form); error unless iImm[31:5] all ones.
- Undefined: all SYSTEM funct3 use plain I-type rule above; rs1 field=iRs1.

Test Plan:
- addi: opcode 0010011, f3 000, rd 1, rs1 0, imm 5 -> oInstr=0x00500093, oErr=0, oValid exactly 2 cycles after accept.
- Store, branch, jump, upper:
  - sw rs1=1, rs2=2, imm 8 -> 0x0020A423.
  - beq x0,x0, imm -4 -> 0xFE000EE3.
  - jal rd=1, imm 2048 -> 0x001000EF.
  - lui rd=5, imm 0x12345000 -> 0x123452B7.
  - All oErr=0.
- Range errors:
  - addi imm 2048 -> oErr=1.
  - beq imm 3 -> oErr=1.
  - lui imm 0x12345001 -> oErr=1.
  - Unknown opcode 0000000 -> 0x00000013, oErr=1.
  - oErrCount=4 after handoffs.
- Back-pressure:
  - Stream 4 back-to-back requests, iReady=0 for 3 cycles mid-stream.
  - oReady drops once both stages full.
  - No loss/duplication; order preserved; oInstr stable while stalled.
- Reset mid-operation:
  - Assert iRST asynchronously with both stages full -> oValid=0, oErrCount=0 immediately (same cycle, before next clock edge).
  - First post-reset request emerges after 2 cycles.
- Counter saturation with CNT_W=2:
  - 5 errored handoffs -> oErrCount sticks at 3.
- With IMMENC_CSR_EN: f3 111, imm 0xFFFFFFFA -> rs1 field=5, oErr=0.

Source files
------------

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: packs opcode/funct/register fields and a decoded immediate into a 32-bit word.
// Optional macro IMMENC_CSR_EN enables CSR-immediate encoding for SYSTEM funct3 101/110/111.
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic [6:0]       iOpcode,
    input  logic [2:0]       iFunct3,
    input  logic [6:0]       iFunct7,
    input  logic [4:0]       iRd,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [31:0]      iImm,
    output logic             oValid,
    input  logic             iReady,
    output logic [31:0]      oInstr,
    output logic             oErr,
    output logic [CNT_W-1:0] oErrCount
);

    logic             vld_p1, vld_p2;
    logic [6:0]       opcode_p1, funct7_p1;
    logic [2:0]       funct3_p1;
    logic [4:0]       rd_p1, rs1_p1, rs2_p1;
    logic [31:0]      imm_p1;
    logic [31:0]      instr_p2;
    logic             err_p2;
    logic [CNT_W-1:0] errcnt;
    logic             s1_load, s2_load;
    logic [32:0]      enc_p1;

    // Bit 32 of the result is the error flag, bits 31:0 the encoded word.
    function automatic logic [32:0] encode(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic        e;
        w = 32'h0;
        e = 1'b0;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w = {imm[11:0], rs1, f3, rd, op};
                e = (imm[31:11] != {21{imm[11]}});
            end
            7'b0100011: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e = (imm[31:11] != {21{imm[11]}});
            end
            7'b1100011: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e = imm[0] | (imm[31:12] != {20{imm[12]}});
            end
            7'b0110111, 7'b0010111: begin
                w = {imm[31:12], rd, op};
                e = |imm[11:0];
            end
            7'b1101111: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e = imm[0] | (imm[31:20] != {12{imm[20]}});
            end
            7'b0110011: begin
                w = {f7, rs2, rs1, f3, rd, op};
            end
            7'b1110011: begin
`ifdef IMMENC_CSR_EN
                if (f3 == 3'b101 || f3 == 3'b110) begin
                    w = {f7, rs2, imm[4:0], f3, rd, op};
                    e = |imm[31:5];
                end else if (f3 == 3'b111) begin
                    // Immediate arrives complemented; restore the raw uimm field.
                    w = {f7, rs2, ~imm[4:0], f3, rd, op};
                    e = ~&imm[31:5];
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                end
`else
                w = {imm[11:0], rs1, f3, rd, op};
`endif
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    assign s2_load = ~vld_p2 | iReady;
    assign s1_load = ~vld_p1 | s2_load;
    assign oReady  = s1_load;
    assign enc_p1  = encode(opcode_p1, funct3_p1, funct7_p1, rd_p1, rs1_p1, rs2_p1, imm_p1);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_load) vld_p1 <= iValid;
            if (s2_load) vld_p2 <= vld_p1;
        end
    end

    // ---- stage S1: capture request fields ----
    always_ff @(posedge iCLK) begin
        if (s1_load && iValid) begin
            opcode_p1 <= iOpcode;
            funct3_p1 <= iFunct3;
            funct7_p1 <= iFunct7;
            rd_p1     <= iRd;
            rs1_p1    <= iRs1;
            rs2_p1    <= iRs2;
            imm_p1    <= iImm;
        end
    end

    // ---- stage S2: encoded word and error flag ----
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            instr_p2 <= 32'h0;
            err_p2   <= 1'b0;
        end else if (s2_load && vld_p1) begin
            instr_p2 <= enc_p1[31:0];
            err_p2   <= enc_p1[32];
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            errcnt <= '0;
        end else if (vld_p2 && iReady && err_p2 && (errcnt != {CNT_W{1'b1}})) begin
            errcnt <= errcnt + 1'b1;
        end
    end

    assign oValid    = vld_p2;
    assign oInstr    = instr_p2;
    assign oErr      = err_p2;
    assign oErrCount = errcnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: table of encodings, back-pressure, async reset and counter saturation.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        iRST;
    logic        iValid, iReady;
    logic [6:0]  iOpcode, iFunct7;
    logic [2:0]  iFunct3;
    logic [4:0]  iRd, iRs1, iRs2;
    logic [31:0] iImm;

    logic        oReady, oValid, oErr;
    logic [31:0] oInstr;
    logic [7:0]  oErrCount;
    logic        oReady2, oValid2, oErr2;
    logic [31:0] oInstr2;
    logic [1:0]  oErrCount2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imm_encoder u_dut (
        .iCLK(clk), .iRST(iRST), .iValid(iValid), .oReady(oReady),
        .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
        .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
        .oValid(oValid), .iReady(iReady), .oInstr(oInstr), .oErr(oErr),
        .oErrCount(oErrCount)
    );

    imm_encoder #(.CNT_W(2)) u_sat (
        .iCLK(clk), .iRST(iRST), .iValid(iValid), .oReady(oReady2),
        .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
        .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm),
        .oValid(oValid2), .iReady(iReady), .oInstr(oInstr2), .oErr(oErr2),
        .oErrCount(oErrCount2)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(input vec_t v);
        iOpcode = v.op;
        iFunct3 = v.f3;
        iFunct7 = v.f7;
        iRd     = v.rd;
        iRs1    = v.rs1;
        iRs2    = v.rs2;
        iImm    = v.imm;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        iValid = 1'b1;
        iReady = 1'b1;
        #1;
        chk({v.name, " ready"}, 32'(oReady), 32'd1);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        n = 1;
        while (!oValid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({v.name, " latency"}, 32'(n), 32'd2);
        chk({v.name, " instr"}, oInstr, v.exp_instr);
        chk({v.name, " err"}, 32'(oErr), 32'(v.exp_err));
        @(posedge clk);
        #1;
        chk({v.name, " drained"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired before finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bexp[4];
        logic [31:0] held;
        bit          held_v;
        bit          saw_drop;
        int          sent, got;

        vt[0] = '{"addi",     7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 1'b0};
        vt[1] = '{"sw",       7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_A423, 1'b0};
        vt[2] = '{"beq",      7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vt[3] = '{"jal",      7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0010_00EF, 1'b0};
        vt[4] = '{"lui",      7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vt[5] = '{"addi_big", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h8000_0093, 1'b1};
        vt[6] = '{"beq_odd",  7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,        32'h0000_0163, 1'b1};
        vt[7] = '{"lui_low",  7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1};
        vt[8] = '{"unknown",  7'h00, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 32'd0,        32'h0000_0013, 1'b1};
`ifdef IMMENC_CSR_EN
        vt[9] = '{"csrrci",   7'h73, 3'd7, 7'd0, 5'd1, 5'd3, 5'd1, 32'hFFFF_FFFA, 32'h0012_F0F3, 1'b0};
`else
        vt[9] = '{"csr_plain",7'h73, 3'd7, 7'd0, 5'd1, 5'd3, 5'd1, 32'hFFFF_FFFA, 32'hFFA1_F0F3, 1'b0};
`endif

        iRST = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        drive(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst oValid", 32'(oValid), 32'd0);
        chk("rst oInstr", oInstr, 32'd0);
        chk("rst oErr", 32'(oErr), 32'd0);
        chk("rst oErrCount", 32'(oErrCount), 32'd0);
        chk("rst oReady", 32'(oReady), 32'd1);
        @(negedge clk);
        iRST = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vt[i]);
        chk("errcount after table", 32'(oErrCount), 32'd4);
        chk("errcount2 after table", 32'(oErrCount2), 32'd3);

        // Back-pressure: four addi requests, sink stalls for cycles 2..4.
        for (int i = 0; i < 4; i++) bexp[i] = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
        sent = 0; got = 0; held = 32'h0; held_v = 1'b0; saw_drop = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            iReady = !(cyc >= 2 && cyc <= 4);
            if (sent < 4) begin
                iValid = 1'b1; iOpcode = 7'h13; iFunct3 = 3'd0; iFunct7 = 7'd0;
                iRd = 5'(sent + 1); iRs1 = 5'd0; iRs2 = 5'd0; iImm = 32'(sent + 1);
            end else begin
                iValid = 1'b0;
            end
            #1;
            if (iValid && !oReady) saw_drop = 1'b1;
            if (oValid && !iReady) begin
                if (held_v) chk("bp stall hold", oInstr, held);
                held = oInstr;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (oValid && iReady) begin
                if (got < 4) chk("bp order", oInstr, bexp[got]);
                got++;
            end
            if (iValid && oReady) sent++;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        chk("bp sent", 32'(sent), 32'd4);
        chk("bp received", 32'(got), 32'd4);
        chk("bp ready dropped", 32'(saw_drop), 32'd1);

        // Fill both stages with an errored word, then reset asynchronously.
        @(negedge clk);
        drive(vt[8]);
        iReady = 1'b0;
        iValid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        iValid = 1'b0;
        #1;
        chk("full oValid", 32'(oValid), 32'd1);
        chk("full oReady", 32'(oReady), 32'd0);
        #1;
        iRST = 1'b1;
        #1;
        chk("async rst oValid", 32'(oValid), 32'd0);
        chk("async rst oErrCount", 32'(oErrCount), 32'd0);
        chk("async rst oErrCount2", 32'(oErrCount2), 32'd0);
        chk("async rst oInstr", oInstr, 32'd0);
        #1;
        iRST = 1'b0;
        iReady = 1'b1;
        run_vec(vt[0]);

        for (int i = 0; i < 5; i++) run_vec(vt[8]);
        chk("errcount 5", 32'(oErrCount), 32'd5);
        chk("errcount2 saturated", 32'(oErrCount2), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
